// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the single-clock and dual-clock FIFO controllers.
package fifo_pkg;

  localparam bit L_MODE_STD  = 1'b0;
  localparam bit L_MODE_FWFT = 1'b1;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module sync_fifo_mem #(
  parameter int P_DATA_MSB = 7,
  parameter int P_ADDR_W   = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [P_ADDR_W-1:0]   i_wr_addr,
  input  logic [P_DATA_MSB:0]   i_wr_data,
  input  logic                  i_rd_en,
  input  logic [P_ADDR_W-1:0]   i_rd_addr,
  output logic [P_DATA_MSB:0]   o_rd_data
);

  logic [P_DATA_MSB:0] mem_q [2**P_ADDR_W];
  logic [P_DATA_MSB:0] rd_data_q, rd_data_d;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) rd_data_d = mem_q[i_rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost flags, overflow/underflow pulses and optional FWFT head stage.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int P_DATA_MSB      = 7,
  parameter int P_DEPTH         = 128,
  parameter int P_FWFT          = 0,
  parameter int P_AFULL_THRESH  = 120,
  parameter int P_AEMPTY_THRESH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_inc,
  input  logic [P_DATA_MSB:0]      i_wr_data,
  output logic                     o_full,
  output logic                     o_afull,
  output logic                     o_overflow,
  input  logic                     i_rd_inc,
  output logic [P_DATA_MSB:0]      o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_empty,
  output logic                     o_aempty,
  output logic                     o_underflow,
  output logic [$clog2(P_DEPTH):0] o_level
);

  localparam int L_PW   = ptr_width(P_DEPTH);
  localparam int L_AW   = L_PW - 1;
  localparam bit L_FWFT = (P_FWFT == int'(L_MODE_FWFT));

  logic [L_PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic                full_q, full_d, afull_q, afull_d, empty_q, empty_d, aempty_q, aempty_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic                rd_valid_q, rd_valid_d, head_sel_q, head_sel_d;
  logic [P_DATA_MSB:0] byp_q, byp_d, ram_dout;
  logic                wr_acc, rd_acc, need_head, fetch, bypass, ram_wr, ram_rd, head_valid;

  always_comb begin
    wr_acc     = i_wr_inc & ~full_q;
    rd_acc     = i_rd_inc & ~empty_q;
    need_head  = empty_q | rd_acc;
    fetch      = 1'b0;
    bypass     = 1'b0;
    ram_wr     = wr_acc;
    ram_rd     = rd_acc;
    head_valid = 1'b0;
    if (L_FWFT) begin
      // The RAM only holds words behind the head; a write into an empty head skips the RAM.
      fetch      = need_head & (level_q >= L_PW'(2));
      bypass     = need_head & (level_q < L_PW'(2)) & wr_acc;
      ram_wr     = wr_acc & ~bypass;
      ram_rd     = fetch;
      head_valid = need_head ? (fetch | bypass) : 1'b1;
    end

    wr_ptr_d    = wr_ptr_q + L_PW'(ram_wr);
    rd_ptr_d    = rd_ptr_q + L_PW'(ram_rd);
    level_d     = (wr_ptr_d - rd_ptr_d) + L_PW'(head_valid);
    full_d      = (level_d == L_PW'(P_DEPTH));
    afull_d     = (level_d >= L_PW'(P_AFULL_THRESH));
    empty_d     = (level_d == '0);
    aempty_d    = (level_d <= L_PW'(P_AEMPTY_THRESH));
    overflow_d  = i_wr_inc & full_q;
    underflow_d = i_rd_inc & empty_q;
    rd_valid_d  = rd_acc;

    head_sel_d = head_sel_q;
    byp_d      = byp_q;
    if (bypass) begin
      head_sel_d = 1'b1;
      byp_d      = i_wr_data;
    end else if (fetch) begin
      head_sel_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      head_sel_q  <= 1'b1;
      byp_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      head_sel_q  <= head_sel_d;
      byp_q       <= byp_d;
    end
  end

  sync_fifo_mem #(
    .P_DATA_MSB (P_DATA_MSB),
    .P_ADDR_W   (L_AW)
  ) u_mem (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (ram_wr),
    .i_wr_addr  (wr_ptr_q[L_AW-1:0]),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (ram_rd),
    .i_rd_addr  (rd_ptr_q[L_AW-1:0]),
    .o_rd_data  (ram_dout)
  );

  assign o_rd_data   = (L_FWFT && head_sel_q) ? byp_q : ram_dout;
  assign o_rd_valid  = L_FWFT ? ~empty_q : rd_valid_q;
  assign o_full      = full_q;
  assign o_afull     = afull_q;
  assign o_empty     = empty_q;
  assign o_aempty    = aempty_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
  assign o_level     = level_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo in standard and FWFT modes (depth 4, afull 3, aempty 1).
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s_wr, s_rd, s_full, s_afull, s_ovf, s_rv, s_empty, s_aempty, s_udf;
  logic [7:0] s_wd, s_rdata;
  logic [2:0] s_level;
  logic       f_wr, f_rd, f_full, f_afull, f_ovf, f_rv, f_empty, f_aempty, f_udf;
  logic [7:0] f_wd, f_rdata;
  logic [2:0] f_level;

  sync_fifo #(.P_DATA_MSB(7), .P_DEPTH(4), .P_FWFT(0), .P_AFULL_THRESH(3), .P_AEMPTY_THRESH(1)) u_std (
    .i_clk(clk), .i_rst(rst), .i_wr_inc(s_wr), .i_wr_data(s_wd), .o_full(s_full), .o_afull(s_afull),
    .o_overflow(s_ovf), .i_rd_inc(s_rd), .o_rd_data(s_rdata), .o_rd_valid(s_rv), .o_empty(s_empty),
    .o_aempty(s_aempty), .o_underflow(s_udf), .o_level(s_level));

  sync_fifo #(.P_DATA_MSB(7), .P_DEPTH(4), .P_FWFT(1), .P_AFULL_THRESH(3), .P_AEMPTY_THRESH(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_wr_inc(f_wr), .i_wr_data(f_wd), .o_full(f_full), .o_afull(f_afull),
    .o_overflow(f_ovf), .i_rd_inc(f_rd), .o_rd_data(f_rdata), .o_rd_valid(f_rv), .o_empty(f_empty),
    .o_aempty(f_aempty), .o_underflow(f_udf), .o_level(f_level));

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  bit [7:0] q_s[$];
  bit [7:0] q_f[$];
  bit [7:0] last_s = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=0x%0h exp=0x%0h", tag, step_no, act, exp);
    end
  endtask

  // One clock of stimulus on the selected DUT, then compare every output with the model.
  task automatic step(input bit fw, input bit wr, input bit [7:0] d, input bit rd);
    int lev;
    bit wacc, racc, ovf, udf;
    logic [31:0] o_lev, o_full, o_afull, o_empty, o_aempty, o_ovf, o_udf, o_rv, o_data;
    step_no++;
    lev  = fw ? q_f.size() : q_s.size();
    wacc = wr && (lev != 4);
    racc = rd && (lev != 0);
    ovf  = wr && (lev == 4);
    udf  = rd && (lev == 0);
    if (fw) begin
      if (racc) check_val("fwft_head_pop", 32'(f_rdata), 32'(q_f[0]));
      f_wr = wr; f_wd = d; f_rd = rd;
    end else begin
      s_wr = wr; s_wd = d; s_rd = rd;
    end
    @(posedge clk);
    #1;
    f_wr = 1'b0; f_rd = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
    if (fw) begin
      if (racc) void'(q_f.pop_front());
      if (wacc) q_f.push_back(d);
      lev = q_f.size();
      o_lev = 32'(f_level); o_full = 32'(f_full); o_afull = 32'(f_afull); o_empty = 32'(f_empty);
      o_aempty = 32'(f_aempty); o_ovf = 32'(f_ovf); o_udf = 32'(f_udf); o_rv = 32'(f_rv); o_data = 32'(f_rdata);
    end else begin
      if (racc) last_s = q_s.pop_front();
      if (wacc) q_s.push_back(d);
      lev = q_s.size();
      o_lev = 32'(s_level); o_full = 32'(s_full); o_afull = 32'(s_afull); o_empty = 32'(s_empty);
      o_aempty = 32'(s_aempty); o_ovf = 32'(s_ovf); o_udf = 32'(s_udf); o_rv = 32'(s_rv); o_data = 32'(s_rdata);
    end
    check_val("level",     o_lev,    32'(lev));
    check_val("full",      o_full,   32'(lev == 4));
    check_val("afull",     o_afull,  32'(lev >= 3));
    check_val("empty",     o_empty,  32'(lev == 0));
    check_val("aempty",    o_aempty, 32'(lev <= 1));
    check_val("overflow",  o_ovf,    32'(ovf));
    check_val("underflow", o_udf,    32'(udf));
    if (fw) begin
      check_val("fwft_valid", o_rv, 32'(lev != 0));
      if (lev != 0) check_val("fwft_head", o_data, 32'(q_f[0]));
    end else begin
      check_val("std_valid", o_rv, 32'(racc));
      check_val("std_data", o_data, 32'(last_s));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_s_level"},  32'(s_level), 32'd0);
    check_val({tag, "_s_empty"},  32'(s_empty), 32'd1);
    check_val({tag, "_s_aempty"}, 32'(s_aempty), 32'd1);
    check_val({tag, "_s_full"},   32'(s_full), 32'd0);
    check_val({tag, "_s_afull"},  32'(s_afull), 32'd0);
    check_val({tag, "_s_flow"},   32'({s_ovf, s_udf}), 32'd0);
    check_val({tag, "_s_rv"},     32'(s_rv), 32'd0);
    check_val({tag, "_s_data"},   32'(s_rdata), 32'd0);
    check_val({tag, "_f_level"},  32'(f_level), 32'd0);
    check_val({tag, "_f_empty"},  32'(f_empty), 32'd1);
    check_val({tag, "_f_rv"},     32'(f_rv), 32'd0);
    check_val({tag, "_f_data"},   32'(f_rdata), 32'd0);
  endtask

  initial begin
    s_wr = 1'b0; s_rd = 1'b0; s_wd = 8'h00;
    f_wr = 1'b0; f_rd = 1'b0; f_wd = 8'h00;
    #11;
    check_reset_outputs("reset");
    #1 rst = 1'b0;

    // Fill to full with overflow, then drain with underflow, in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) step(m[0], 1'b1, 8'hA0 + 8'(i), 1'b0);
      step(m[0], 1'b1, 8'hA4, 1'b0);
      for (int i = 0; i < 5; i++) step(m[0], 1'b0, 8'h00, 1'b1);
    end

    // FWFT single-word fall-through.
    step(1'b1, 1'b1, 8'h5C, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Simultaneous read+write at mid level, full and empty.
    for (int m = 0; m < 2; m++) begin
      step(m[0], 1'b1, 8'hB0, 1'b0);
      step(m[0], 1'b1, 8'hB1, 1'b0);
      step(m[0], 1'b1, 8'hB2, 1'b1);
      step(m[0], 1'b1, 8'hB3, 1'b0);
      step(m[0], 1'b1, 8'hB4, 1'b0);
      step(m[0], 1'b1, 8'hEE, 1'b1);
      for (int i = 0; i < 3; i++) step(m[0], 1'b0, 8'h00, 1'b1);
      step(m[0], 1'b1, 8'hC0, 1'b1);
      step(m[0], 1'b0, 8'h00, 1'b1);
    end

    // Interleaved pairs across the pointer wrap, then same-cycle pairs.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10; i++) begin
        step(m[0], 1'b1, 8'h30 + 8'(i), 1'b0);
        step(m[0], 1'b0, 8'h00, 1'b1);
      end
      step(m[0], 1'b1, 8'h60, 1'b0);
      for (int i = 1; i < 11; i++) step(m[0], 1'b1, 8'h60 + 8'(i), 1'b1);
      step(m[0], 1'b0, 8'h00, 1'b1);
    end

    // Random traffic on both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 60; i++)
        step(m[0], 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset mid-stream at level 3, then recover.
    for (int m = 0; m < 2; m++) begin
      while ((m == 0 ? q_s.size() : q_f.size()) > 0) step(m[0], 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) step(m[0], 1'b1, 8'h90 + 8'(i), 1'b0);
    end
    #3 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    q_s.delete();
    q_f.delete();
    last_s = 8'h00;
    #2 rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      step(m[0], 1'b1, 8'h11, 1'b0);
      step(m[0], 1'b0, 8'h00, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
